time_set_ctrl: RTL

- Front-end user-input block for the decade clock.
- Debounces the three push buttons and runs an edit state machine that walks the time and date fields.
- Holds shadow copies of each field and applies increment/decrement with calendar-correct wrap.
- Emits a one-cycle load strobe with the edited values, which the clock/calendar core copies into its counters.

---
 rtl/time_set_ctrl_if.sv | 36 +++
 rtl/time_set_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl_if.sv
// Button, live-time and edited-time signals between the decade clock core and
// its time-setting front end.
interface time_set_ctrl_if;
    logic        butt_increase;
    logic        butt_decrease;
    logic        butt_change;
    logic [5:0]  cur_sec;
    logic [5:0]  cur_min;
    logic [4:0]  cur_hour;
    logic [4:0]  cur_day;
    logic [3:0]  cur_month;
    logic [13:0] cur_year;
    logic [5:0]  set_sec;
    logic [5:0]  set_min;
    logic [4:0]  set_hour;
    logic [4:0]  set_day;
    logic [3:0]  set_month;
    logic [13:0] set_year;
    logic        load;
    logic        editing;
    logic [2:0]  field;

    modport master (
        output butt_increase, butt_decrease, butt_change,
        output cur_sec, cur_min, cur_hour, cur_day, cur_month, cur_year,
        input  set_sec, set_min, set_hour, set_day, set_month, set_year,
        input  load, editing, field
    );

    modport slave (
        input  butt_increase, butt_decrease, butt_change,
        input  cur_sec, cur_min, cur_hour, cur_day, cur_month, cur_year,
        output set_sec, set_min, set_hour, set_day, set_month, set_year,
        output load, editing, field
    );
endinterface

// File: rtl/time_set_ctrl.sv
// Debounced three-button time/date editor with calendar-correct wrap and a one-cycle load strobe.
// Optional feature: define AUTOREPEAT_EN for held-button auto-repeat.
module time_set_ctrl #(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int YEAR_MIN     = 2000,
    parameter int YEAR_MAX     = 2099,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_CYC   = 5_000_000
) (
    input  logic           clk,
    input  logic           rst_n,
    time_set_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, EDIT_HOUR, EDIT_MIN, EDIT_SEC, EDIT_DAY, EDIT_MONTH, EDIT_YEAR, COMMIT
    } state_t;

    localparam int              DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYC);
    localparam logic [13:0]     Y_MIN  = 14'(YEAR_MIN);
    localparam logic [13:0]     Y_MAX  = 14'(YEAR_MAX);

    if (DEBOUNCE_CYC < 1 || REPEAT_DELAY < 1 || REPEAT_CYC < 1 || YEAR_MAX < YEAR_MIN) begin : g_bad_param
        $error("time_set_ctrl: invalid parameter set");
    end

    function automatic logic is_leap(input logic [13:0] y);
        return (y % 14'd4 == 14'd0) && ((y % 14'd100 != 14'd0) || (y % 14'd400 == 14'd0));
    endfunction

    function automatic logic [4:0] max_day(input logic [3:0] m, input logic [13:0] y);
        logic [4:0] d;
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
            4'd2:                    d = is_leap(y) ? 5'd29 : 5'd28;
            default:                 d = 5'd31;
        endcase
        return d;
    endfunction

    // Bit order everywhere in the button path: [0] increase, [1] decrease, [2] change; 1 = released.
    logic [2:0]      raw_n, sync1_q, sync2_q, lvl_q, deb_q, deb_d, deb_prev_q, press_ev;
    logic [DB_W-1:0] db_cnt_q [3];
    logic [DB_W-1:0] db_cnt_d [3];

    assign raw_n    = {bus.butt_change, bus.butt_decrease, bus.butt_increase};
    assign press_ev = deb_prev_q & ~deb_q;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            deb_d[i]    = deb_q[i];
            if (sync2_q[i] != lvl_q[i])
                db_cnt_d[i] = '0;
            else if (db_cnt_q[i] != DB_MAX)
                db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            if (db_cnt_q[i] == DB_MAX)
                deb_d[i] = lvl_q[i];
        end
    end

    state_t      state_q, state_d;
    logic [4:0]  hour_q, hour_d, day_q, day_d, set_hour_q, set_hour_d, set_day_q, set_day_d;
    logic [5:0]  min_q, min_d, sec_q, sec_d, set_min_q, set_min_d, set_sec_q, set_sec_d;
    logic [3:0]  month_q, month_d, set_month_q, set_month_d;
    logic [13:0] year_q, year_d, set_year_q, set_year_d;
    logic        load_q, load_d, editing_q, editing_d;
    logic [2:0]  field_q, field_d;
    logic        inc_ev, dec_ev, chg_ev;

    assign chg_ev = press_ev[2];

`ifdef AUTOREPEAT_EN
    logic [31:0] rep_cnt_q, rep_cnt_d;
    logic        rep_run_q, rep_run_d;
    logic [1:0]  rep_fire;
    logic        held_inc, held_dec, in_edit;

    assign held_inc = ~deb_q[0] &  deb_q[1];
    assign held_dec =  deb_q[0] & ~deb_q[1];
    assign in_edit  = (state_q != IDLE) && (state_q != COMMIT);

    // First repeat after REPEAT_DELAY cycles of holding, then every REPEAT_CYC.
    always_comb begin
        rep_cnt_d = rep_cnt_q;
        rep_run_d = rep_run_q;
        rep_fire  = 2'b00;
        if (!in_edit || chg_ev || press_ev[0] || press_ev[1] || !(held_inc || held_dec)) begin
            rep_cnt_d = '0;
            rep_run_d = 1'b0;
        end else if (rep_cnt_q == (rep_run_q ? 32'(REPEAT_CYC - 1) : 32'(REPEAT_DELAY - 1))) begin
            rep_fire  = {held_dec, held_inc};
            rep_cnt_d = '0;
            rep_run_d = 1'b1;
        end else begin
            rep_cnt_d = rep_cnt_q + 32'd1;
        end
    end

    assign inc_ev = press_ev[0] | rep_fire[0];
    assign dec_ev = press_ev[1] | rep_fire[1];
`else
    assign inc_ev = press_ev[0];
    assign dec_ev = press_ev[1];
`endif

    logic        up, step;
    logic [3:0]  cap_month, month_n;
    logic [13:0] cap_year, year_n;
    logic [4:0]  cap_day, md_now, md_month, md_year;

    assign up        = inc_ev;
    assign step      = inc_ev ^ dec_ev;
    assign cap_month = (bus.cur_month >= 4'd1 && bus.cur_month <= 4'd12) ? bus.cur_month : 4'd1;
    assign cap_year  = (bus.cur_year >= Y_MIN && bus.cur_year <= Y_MAX) ? bus.cur_year : Y_MIN;
    assign cap_day   = (bus.cur_day >= 5'd1 && bus.cur_day <= max_day(cap_month, cap_year)) ? bus.cur_day : 5'd1;
    assign month_n   = up ? ((month_q == 4'd12) ? 4'd1 : month_q + 4'd1)
                          : ((month_q == 4'd1) ? 4'd12 : month_q - 4'd1);
    assign year_n    = up ? ((year_q == Y_MAX) ? Y_MIN : year_q + 14'd1)
                          : ((year_q == Y_MIN) ? Y_MAX : year_q - 14'd1);
    assign md_now    = max_day(month_q, year_q);
    assign md_month  = max_day(month_n, year_q);
    assign md_year   = max_day(month_q, year_n);

    always_comb begin
        state_d     = state_q;
        hour_d      = hour_q;
        min_d       = min_q;
        sec_d       = sec_q;
        day_d       = day_q;
        month_d     = month_q;
        year_d      = year_q;
        set_hour_d  = set_hour_q;
        set_min_d   = set_min_q;
        set_sec_d   = set_sec_q;
        set_day_d   = set_day_q;
        set_month_d = set_month_q;
        set_year_d  = set_year_q;
        load_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (chg_ev) begin
                    state_d = EDIT_HOUR;
                    hour_d  = (bus.cur_hour <= 5'd23) ? bus.cur_hour : 5'd0;
                    min_d   = (bus.cur_min  <= 6'd59) ? bus.cur_min  : 6'd0;
                    sec_d   = (bus.cur_sec  <= 6'd59) ? bus.cur_sec  : 6'd0;
                    day_d   = cap_day;
                    month_d = cap_month;
                    year_d  = cap_year;
                end
            end
            COMMIT: state_d = IDLE;
            default: begin
                if (chg_ev) begin
                    state_d = state_t'(state_q + 3'd1);
                end else if (step) begin
                    case (state_q)
                        EDIT_HOUR: hour_d = up ? ((hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1)
                                               : ((hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1);
                        EDIT_MIN:  min_d  = up ? ((min_q == 6'd59) ? 6'd0 : min_q + 6'd1)
                                               : ((min_q == 6'd0) ? 6'd59 : min_q - 6'd1);
                        EDIT_SEC:  sec_d  = up ? ((sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1)
                                               : ((sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1);
                        EDIT_DAY:  day_d  = up ? ((day_q >= md_now) ? 5'd1 : day_q + 5'd1)
                                               : ((day_q <= 5'd1) ? md_now : day_q - 5'd1);
                        EDIT_MONTH: begin
                            month_d = month_n;
                            if (day_q > md_month) day_d = md_month;
                        end
                        EDIT_YEAR: begin
                            year_d = year_n;
                            if (day_q > md_year) day_d = md_year;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
        // Outputs are computed from the next state so they line up with it without a cycle of lag.
        if (state_d == COMMIT) begin
            load_d      = 1'b1;
            set_hour_d  = hour_q;
            set_min_d   = min_q;
            set_sec_d   = sec_q;
            set_day_d   = day_q;
            set_month_d = month_q;
            set_year_d  = year_q;
        end
        editing_d = (state_d != IDLE) && (state_d != COMMIT);
        field_d   = editing_d ? 3'(state_d) : 3'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 3'b111;
            sync2_q     <= 3'b111;
            lvl_q       <= 3'b111;
            deb_q       <= 3'b111;
            deb_prev_q  <= 3'b111;
            db_cnt_q    <= '{default: '0};
            state_q     <= IDLE;
            hour_q      <= 5'd0;
            min_q       <= 6'd0;
            sec_q       <= 6'd0;
            day_q       <= 5'd1;
            month_q     <= 4'd1;
            year_q      <= 14'd2024;
            set_hour_q  <= 5'd0;
            set_min_q   <= 6'd0;
            set_sec_q   <= 6'd0;
            set_day_q   <= 5'd1;
            set_month_q <= 4'd1;
            set_year_q  <= 14'd2024;
            load_q      <= 1'b0;
            editing_q   <= 1'b0;
            field_q     <= 3'd0;
`ifdef AUTOREPEAT_EN
            rep_cnt_q   <= '0;
            rep_run_q   <= 1'b0;
`endif
        end else begin
            sync1_q     <= raw_n;
            sync2_q     <= sync1_q;
            lvl_q       <= sync2_q;
            deb_q       <= deb_d;
            deb_prev_q  <= deb_q;
            db_cnt_q    <= db_cnt_d;
            state_q     <= state_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            day_q       <= day_d;
            month_q     <= month_d;
            year_q      <= year_d;
            set_hour_q  <= set_hour_d;
            set_min_q   <= set_min_d;
            set_sec_q   <= set_sec_d;
            set_day_q   <= set_day_d;
            set_month_q <= set_month_d;
            set_year_q  <= set_year_d;
            load_q      <= load_d;
            editing_q   <= editing_d;
            field_q     <= field_d;
`ifdef AUTOREPEAT_EN
            rep_cnt_q   <= rep_cnt_d;
            rep_run_q   <= rep_run_d;
`endif
        end
    end

    assign bus.set_hour  = set_hour_q;
    assign bus.set_min   = set_min_q;
    assign bus.set_sec   = set_sec_q;
    assign bus.set_day   = set_day_q;
    assign bus.set_month = set_month_q;
    assign bus.set_year  = set_year_q;
    assign bus.load      = load_q;
    assign bus.editing   = editing_q;
    assign bus.field     = field_q;

endmodule
